// File: rtl/delay_key_pkg.sv
// Shared types for the push-button delay controller front end.
package delay_key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_LOCK   = 2'd3
    } state_e;

    // Value doubles as the key index inside the top module.
    typedef enum logic {
        DIR_SLOWER = 1'b0,
        DIR_FASTER = 1'b1
    } dir_e;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser followed by a counting debouncer for one active-low key.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic pressed
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;   // tracks the key level: 1 = released

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            deb_q  <= 1'b1;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

    always_comb begin
        sync_d = {sync_q[0], key_n};
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        if (sync_q[1] == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
            deb_d = ~deb_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign pressed = ~deb_q;

endmodule

// File: rtl/delay_key_ctrl.sv
// Turns the slower/faster push-buttons into single-cycle, auto-repeating,
// range-guarded requests for the HPS delay controller.
module delay_key_ctrl
    import delay_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_START    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int DELAY_MAX       = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_slower_n,
    input  logic       key_faster_n,
    input  logic [3:0] delay,
    output logic       slower,
    output logic       faster,
    output logic       lockout
);
    localparam int RMAX = (REPEAT_START > REPEAT_PERIOD) ? REPEAT_START : REPEAT_PERIOD;
    localparam int RCW  = (RMAX > 2) ? $clog2(RMAX) : 1;

    logic [1:0] key_raw_n;
    logic [1:0] pressed;

    assign key_raw_n = {key_faster_n, key_slower_n};

    genvar g;
    for (g = 0; g < 2; g++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .key_n   (key_raw_n[g]),
            .pressed (pressed[g])
        );
    end

    state_e         state_q, state_d;
    dir_e           dir_q, dir_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic           slower_q, slower_d;
    logic           faster_q, faster_d;
    logic           pulse;
    logic           both, none, cur_held;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            dir_q    <= DIR_SLOWER;
            rcnt_q   <= '0;
            slower_q <= 1'b0;
            faster_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            rcnt_q   <= rcnt_d;
            slower_q <= slower_d;
            faster_q <= faster_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        rcnt_d   = '0;
        pulse    = 1'b0;
        both     = &pressed;
        none     = ~|pressed;
        cur_held = (dir_q == DIR_FASTER) ? pressed[1] : pressed[0];
        case (state_q)
            ST_IDLE: begin
                if (both) begin
                    state_d = ST_LOCK;
                end else if (!none) begin
                    state_d = ST_FIRST;
                    dir_d   = pressed[1] ? DIR_FASTER : DIR_SLOWER;
                    pulse   = 1'b1;
                end
            end
            ST_FIRST: begin
                if (both) begin
                    state_d = ST_LOCK;
                end else if (!cur_held) begin
                    state_d = ST_IDLE;
                end else if (rcnt_q == RCW'(REPEAT_START - 1)) begin
                    state_d = ST_REPEAT;
                    pulse   = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + RCW'(1);
                end
            end
            ST_REPEAT: begin
                if (both) begin
                    state_d = ST_LOCK;
                end else if (!cur_held) begin
                    state_d = ST_IDLE;
                end else if (rcnt_q == RCW'(REPEAT_PERIOD - 1)) begin
                    pulse = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + RCW'(1);
                end
            end
            ST_LOCK: begin
                if (none) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // The guard only masks the request; timing keeps running so a held
        // key resumes as soon as delay leaves the limit.
        slower_d = pulse && (dir_d == DIR_SLOWER) && (delay != 4'(DELAY_MAX));
        faster_d = pulse && (dir_d == DIR_FASTER) && (delay != 4'd0);
    end

    assign slower  = slower_q;
    assign faster  = faster_q;
    assign lockout = (state_q == ST_LOCK);

endmodule
